spi_master: RTL and testbench
=============================

# spi_master

Byte-oriented SPI controller (mode 0: CPOL=0, CPHA=0, MSB first). It drives `sclk`, `mosi` and active-low `ss` toward an external SPI peripheral and captures `miso`. It runs entirely in the system `clk` domain and derives `sclk` with a programmable divider. Its FPGA-side handshake is `write`/`byte_send`/`busy` for transmit and `valid`/`byte_recv` for receive, so it is the controller end of the SPI link our peripheral-side block terminates.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period; legal values ≥ 2.
- `GAP_CYCLES`, default 2: idle `clk` cycles with `ss` high after each frame before `busy` drops; legal values ≥ 1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `write`  in  1  start request; accepted only on an edge where `busy`=0.
- `byte_send`  in  8  byte to transmit; sampled on the accepting edge only.
- `byte_recv`  out  8  last received byte; holds until the next frame completes.
- `valid`  out  1  one-cycle pulse when `byte_recv` updates.
- `busy`  out  1  high from acceptance until the end of the gap.
- `sclk`  out  1  SPI clock, idle low.
- `mosi`  out  1  serial data out.
- `ss`  out  1  slave select, active low.
- `miso`  in  1  serial data in from the peripheral.

## Operation
- All outputs are registered.
- Reset values: `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `valid`=0, `byte_recv`=8'h00, state IDLE. An assertion mid-frame aborts immediately and discards any partial received byte.
- Internal registers: phase counter (0..CLK_DIV-1), bit counter (0..7), tx shift register, rx shift register.
- Every timed state lasts exactly CLK_DIV cycles. Its exit action happens on the edge where the counter reaches CLK_DIV-1.
- IDLE:
  - On `write`=1: latch `byte_send`, set `ss`<=0, `busy`<=1, `mosi`<=`byte_send[7]`, bit counter <= 0.
  - Go to SETUP.
- SETUP: on exit, `sclk`<=1 and rx <= {rx[6:0], `miso`}. Go to HIGH.
- HIGH: on exit, `sclk`<=0.
  - If bit counter = 7: go to HOLD, with `mosi` holding bit 0.
  - Otherwise: `mosi`<= next tx bit, increment the bit counter, go to LOW.
- LOW: on exit, `sclk`<=1 and shift `miso` into rx. Go to HIGH.
- HOLD: on exit:
  - `ss`<=1, `mosi`<=0.
  - `byte_recv`<= rx; `valid`<=1 for exactly one cycle.
  - Go to GAP.
- GAP: after GAP_CYCLES cycles, `busy`<=0 and go to IDLE.
- `write` while `busy`=1 is ignored, with no queuing. `byte_send` changes after acceptance have no effect.
- `miso` is sampled on the same `clk` edge that raises `sclk`. This gives CLK_DIV cycles of stability after the peripheral's change on the falling edge.

## Timing
- Let E0 be the accepting edge and D = CLK_DIV.
- `ss` falls and `mosi`=bit7 after E0.
- `sclk` rising edges land at E0+D, E0+3D, …, E0+15D (8 rises). Falling edges land at E0+2D, …, E0+16D.
- `mosi` changes only on falling edges, for bits 6..0 at E0+2D..E0+14D.
- `ss` rises, `valid`=1 and `byte_recv` updates at E0+17D. `valid` returns to 0 at E0+17D+1.
- `busy` falls at E0+17D+GAP_CYCLES. The next `write` is accepted on the first edge after that.
- Frame length from acceptance to `busy` low is 17·D + GAP_CYCLES cycles.
- `sclk` never glitches, and `sclk`=0 whenever `ss` changes.

## Test plan
- Loopback (`miso`=`mosi`), D=4, GAP=2, write 8'hA5 -> 8 `sclk` rises at E0+4,12,…,60; `mosi` sequence 1,0,1,0,0,1,0,1; `valid` pulse at E0+68 with `byte_recv`=8'hA5; `busy` low at E0+70.
- `miso` tied 1, write 8'h00 -> `byte_recv`=8'hFF; `mosi` stays 0 throughout; `ss` low for exactly 68 cycles.
- Write 8'h3C, pulse `write` again with 8'hFF at E0+20 -> second request ignored; only one frame of 0x3C; `busy` falls once.
- Back-to-back: write 8'h12 then hold `write` high with 8'h34 -> second frame accepted at the first edge after `busy`=0; `ss` high ≥ GAP_CYCLES cycles between frames; loopback yields 8'h12 then 8'h34.
- Assert `rst` at E0+30 mid-frame -> same cycle `ss`=1, `sclk`=0, `busy`=0, `valid`=0, `byte_recv`=8'h00; after release a new write of 8'h5A completes normally with `byte_recv`=8'h5A.
- D=2 configuration, loopback 8'hC3 -> `valid` at E0+34, `busy` low at E0+36, `byte_recv`=8'hC3.

Source files
------------

// File: rtl/spi_master.sv
// Mode-0 SPI byte controller: drives sclk/mosi/ss, captures miso MSB first.
// Latency: 17*CLK_DIV cycles from the accepting edge to valid, plus GAP_CYCLES until busy drops.
// Backpressure: write is taken only while busy=0; requests during a frame are dropped, not queued.
module spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic [7:0] byte_send,
  output logic [7:0] byte_recv,
  output logic       valid,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  input  logic       miso
);

  // One counter times both the sclk half-periods and the trailing gap.
  localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    tx_sr, tx_nxt;
  logic [7:0]    rx_sr, rx_nxt;
  logic [7:0]    byte_recv_nxt;
  logic          valid_nxt, busy_nxt, sclk_nxt, mosi_nxt, ss_nxt;
  logic          div_done, gap_done;

  assign div_done = (cnt == CW'(CLK_DIV - 1));
  assign gap_done = (cnt == CW'(GAP_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection: every timed state leaves on its last counted cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (write)    state_nxt = SETUP;
      SETUP:   if (div_done) state_nxt = HIGH;
      HIGH:    if (div_done) state_nxt = (bit_cnt == 3'd7) ? HOLD : LOW;
      LOW:     if (div_done) state_nxt = HIGH;
      HOLD:    if (div_done) state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered below so nothing glitches.
  always_comb begin
    cnt_nxt       = cnt + 1'b1;
    bit_nxt       = bit_cnt;
    tx_nxt        = tx_sr;
    rx_nxt        = rx_sr;
    byte_recv_nxt = byte_recv;
    valid_nxt     = 1'b0;
    busy_nxt      = busy;
    sclk_nxt      = sclk;
    mosi_nxt      = mosi;
    ss_nxt        = ss;
    if (state == IDLE || state_nxt != state) cnt_nxt = '0;
    unique case (state)
      IDLE: begin
        if (write) begin
          tx_nxt   = byte_send;
          ss_nxt   = 1'b0;
          busy_nxt = 1'b1;
          mosi_nxt = byte_send[7];
          bit_nxt  = 3'd0;
        end
      end
      // Rising sclk edge: miso has been stable for a full half-period here.
      SETUP, LOW: begin
        if (div_done) begin
          sclk_nxt = 1'b1;
          rx_nxt   = {rx_sr[6:0], miso};
        end
      end
      // Falling sclk edge: present the next bit, except after bit 0 which is held.
      HIGH: begin
        if (div_done) begin
          sclk_nxt = 1'b0;
          if (bit_cnt != 3'd7) begin
            mosi_nxt = tx_sr[6];
            tx_nxt   = {tx_sr[6:0], 1'b0};
            bit_nxt  = bit_cnt + 3'd1;
          end
        end
      end
      HOLD: begin
        if (div_done) begin
          ss_nxt        = 1'b1;
          mosi_nxt      = 1'b0;
          byte_recv_nxt = rx_sr;
          valid_nxt     = 1'b1;
        end
      end
      GAP: begin
        if (gap_done) busy_nxt = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset aborts a frame and drops partial rx data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      tx_sr     <= 8'h00;
      rx_sr     <= 8'h00;
      byte_recv <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ss        <= 1'b1;
    end else begin
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_nxt;
      tx_sr     <= tx_nxt;
      rx_sr     <= rx_nxt;
      byte_recv <= byte_recv_nxt;
      valid     <= valid_nxt;
      busy      <= busy_nxt;
      sclk      <= sclk_nxt;
      mosi      <= mosi_nxt;
      ss        <= ss_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       write;
  logic [7:0] byte_send;
  logic       lb;
  logic       miso_fix;
  logic       sel;

  logic [7:0] br1, br2;
  logic       v1, v2, b1, b2, sc1, sc2, mo1, mo2, ss1, ss2;
  logic       mi1, mi2, wr1, wr2;

  logic [7:0] m_byte_recv;
  logic       m_valid, m_busy, m_sclk, m_mosi, m_ss;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  assign mi1 = lb ? mo1 : miso_fix;
  assign mi2 = lb ? mo2 : miso_fix;
  assign wr1 = sel ? 1'b0 : write;
  assign wr2 = sel ? write : 1'b0;

  assign m_byte_recv = sel ? br2 : br1;
  assign m_valid     = sel ? v2  : v1;
  assign m_busy      = sel ? b2  : b1;
  assign m_sclk      = sel ? sc2 : sc1;
  assign m_mosi      = sel ? mo2 : mo1;
  assign m_ss        = sel ? ss2 : ss1;

  spi_master #(.CLK_DIV(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .write(wr1), .byte_send(byte_send),
    .byte_recv(br1), .valid(v1), .busy(b1), .sclk(sc1), .mosi(mo1),
    .ss(ss1), .miso(mi1)
  );

  spi_master #(.CLK_DIV(2), .GAP_CYCLES(2)) dut_d2 (
    .clk(clk), .rst(rst), .write(wr2), .byte_send(byte_send),
    .byte_recv(br2), .valid(v2), .busy(b2), .sclk(sc2), .mosi(mo2),
    .ss(ss2), .miso(mi2)
  );

  // Present a request so that the next rising edge is the accepting edge E0.
  task automatic start(input logic [7:0] b);
    @(negedge clk);
    byte_send = b;
    write     = 1'b1;
    @(posedge clk);
  endtask

  // Called just after E0. Walks the frame cycle by cycle against the timing
  // derived from D and GAP; pops the scoreboard whenever valid is seen.
  task automatic drive_frame(input logic [7:0] b, input logic [7:0] exp_rx,
                             input int d, input int g, input int pulse_at,
                             input logic hold, input logic [7:0] next_b,
                             input int abort_at);
    int last;
    int m;
    int idx;
    logic e_sclk, e_ss, e_busy, e_valid, e_mosi;
    logic [7:0] exp_b;
    last = 17 * d + g;
    if (abort_at < 0) sb.push_back(exp_rx);
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      if (k == 0) begin
        if (hold) byte_send = next_b;
        else begin
          write     = 1'b0;
          byte_send = ~b;
        end
      end
      if (k == pulse_at) write = 1'b0;
      m       = k / d;
      idx     = (m / 2 >= 7) ? 0 : 7 - m / 2;
      e_sclk  = (m % 2 == 1) && (m <= 15);
      e_ss    = (k >= 17 * d);
      e_busy  = (k < last);
      e_valid = (k == 17 * d);
      e_mosi  = (k >= 17 * d) ? 1'b0 : b[idx];
      vectors += 5;
      if (m_sclk !== e_sclk) begin
        miscompares++;
        $display("FAIL sclk k=%0d got=%b exp=%b", k, m_sclk, e_sclk);
      end
      if (m_ss !== e_ss) begin
        miscompares++;
        $display("FAIL ss k=%0d got=%b exp=%b", k, m_ss, e_ss);
      end
      if (m_busy !== e_busy) begin
        miscompares++;
        $display("FAIL busy k=%0d got=%b exp=%b", k, m_busy, e_busy);
      end
      if (m_valid !== e_valid) begin
        miscompares++;
        $display("FAIL valid k=%0d got=%b exp=%b", k, m_valid, e_valid);
      end
      if (m_mosi !== e_mosi) begin
        miscompares++;
        $display("FAIL mosi k=%0d got=%b exp=%b", k, m_mosi, e_mosi);
      end
      if (m_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected k=%0d got=%h exp=none", k, m_byte_recv);
        end else begin
          exp_b = sb.pop_front();
          if (m_byte_recv !== exp_b) begin
            miscompares++;
            $display("FAIL byte_recv k=%0d got=%h exp=%h", k, m_byte_recv, exp_b);
          end
        end
      end
      if (k == pulse_at - 1) begin
        write     = 1'b1;
        byte_send = 8'hFF;
      end
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        vectors++;
        if ({m_ss, m_sclk, m_busy, m_valid, m_mosi, m_byte_recv} !== {5'b10000, 8'h00}) begin
          miscompares++;
          $display("FAIL abort_state got=%b/%b/%b/%b/%b/%h exp=1/0/0/0/0/00",
                   m_ss, m_sclk, m_busy, m_valid, m_mosi, m_byte_recv);
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; write = 1'b0; byte_send = 8'h00; lb = 1'b1; miso_fix = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if ({m_ss, m_sclk, m_busy, m_valid, m_mosi, m_byte_recv} !== {5'b10000, 8'h00}) begin
        miscompares++;
        $display("FAIL reset_state inst=%0d got=%b/%b/%b/%b/%b/%h exp=1/0/0/0/0/00",
                 s, m_ss, m_sclk, m_busy, m_valid, m_mosi, m_byte_recv);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_loopback();
    lb = 1'b1;
    start(8'hA5);
    drive_frame(8'hA5, 8'hA5, 4, 2, -10, 1'b0, 8'h00, -1);
  endtask

  task automatic test_miso_high();
    lb = 1'b0; miso_fix = 1'b1;
    start(8'h00);
    drive_frame(8'h00, 8'hFF, 4, 2, -10, 1'b0, 8'h00, -1);
    lb = 1'b1;
  endtask

  task automatic test_ignore_busy();
    start(8'h3C);
    drive_frame(8'h3C, 8'h3C, 4, 2, 20, 1'b0, 8'h00, -1);
    // A swallowed request must not start a frame once idle again.
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (m_busy !== 1'b0 || m_ss !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_idle got busy=%b ss=%b exp busy=0 ss=1", m_busy, m_ss);
    end
  endtask

  task automatic test_back_to_back();
    start(8'h12);
    drive_frame(8'h12, 8'h12, 4, 2, -10, 1'b1, 8'h34, -1);
    @(posedge clk);
    drive_frame(8'h34, 8'h34, 4, 2, -10, 1'b0, 8'h00, -1);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    start(8'h96);
    drive_frame(8'h96, 8'h96, 4, 2, -10, 1'b0, 8'h00, 30);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    start(8'h5A);
    drive_frame(8'h5A, 8'h5A, 4, 2, -10, 1'b0, 8'h00, -1);
  endtask

  task automatic test_div2();
    sel = 1'b1;
    repeat (2) @(posedge clk);
    start(8'hC3);
    drive_frame(8'hC3, 8'hC3, 2, 2, -10, 1'b0, 8'h00, -1);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_high();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_div2();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
